conv1d_reg_initiator: RTL and testbench

Register-interface initiator that drives the conv1d control register block from a simple command stream. A local controller (test sequencer, DMA glue or host shim) pushes single read/write/poll commands; the block turns each one into `conv1d_reg_pkg` request transactions. Each command returns exactly one result (read data, error, timeout). Poll commands repeat a read until a masked compare matches, e.g. waiting on a DONE status bit.

---
 rtl/conv1d_reg_initiator.sv | 194 +++++++++++++++++++
 tb/tb_conv1d_reg_initiator.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv1d_reg_initiator.sv
// conv1d register-interface initiator: turns single read/write/poll commands
// into conv1d_reg_pkg request transactions and returns one result per command.

package conv1d_reg_pkg;
    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        valid;
    } reg_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        error;
        logic        ready;
    } reg_rsp_t;
endpackage

// state | meaning
// IDLE  | waiting for a command, cmd_ready_o=1
// ISSUE | request valid, waiting for rsp_i.ready
// GAP   | poll mismatch, request idle for PollGap cycles before retry
// RESP  | result presented, waiting for res_ready_i
module conv1d_reg_initiator #(
    parameter int AddrWidth   = 32,
    parameter int DataWidth   = 32,
    parameter int PollMaxIter = 1024,
    parameter int PollGap     = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     cmd_valid_i,
    output logic                     cmd_ready_o,
    input  logic [AddrWidth-1:0]     cmd_addr_i,
    input  logic                     cmd_write_i,
    input  logic [DataWidth-1:0]     cmd_wdata_i,
    input  logic                     cmd_poll_i,
    input  logic [DataWidth-1:0]     cmd_mask_i,
    output logic                     res_valid_o,
    input  logic                     res_ready_i,
    output logic [DataWidth-1:0]     res_rdata_o,
    output logic                     res_error_o,
    output logic                     res_timeout_o,
    output conv1d_reg_pkg::reg_req_t req_o,
    input  conv1d_reg_pkg::reg_rsp_t rsp_i
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] GAP   = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    localparam int IterW = $clog2(PollMaxIter + 1);
    localparam int GapW  = $clog2(PollGap + 1);

    logic [1:0]           state_q,   state_d;
    logic [AddrWidth-1:0] addr_q,    addr_d;
    logic                 write_q,   write_d;
    logic [DataWidth-1:0] wdata_q,   wdata_d;
    logic                 poll_q,    poll_d;
    logic [DataWidth-1:0] mask_q,    mask_d;
    logic [IterW-1:0]     iter_q,    iter_d;
    logic [GapW-1:0]      gap_q,     gap_d;
    logic [DataWidth-1:0] rdata_q,   rdata_d;
    logic                 error_q,   error_d;
    logic                 timeout_q, timeout_d;

    logic [IterW-1:0]     iter_inc;
    logic                 poll_match;

    assign iter_inc   = iter_q + 1'b1;
    assign poll_match = ((rsp_i.rdata & mask_q) == (wdata_q & mask_q));

    // Next-state and result/capture logic for the command FSM
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        write_d   = write_q;
        wdata_d   = wdata_q;
        poll_d    = poll_q;
        mask_d    = mask_q;
        iter_d    = iter_q;
        gap_d     = gap_q;
        rdata_d   = rdata_q;
        error_d   = error_q;
        timeout_d = timeout_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid_i) begin
                    addr_d    = cmd_addr_i;
                    write_d   = cmd_write_i;
                    wdata_d   = cmd_wdata_i;
                    poll_d    = cmd_poll_i & ~cmd_write_i;
                    mask_d    = cmd_mask_i;
                    iter_d    = '0;
                    rdata_d   = '0;
                    error_d   = 1'b0;
                    timeout_d = 1'b0;
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                if (rsp_i.ready) begin
                    if (rsp_i.error) begin
                        // Error ends the command at once, poll or not.
                        error_d = 1'b1;
                        rdata_d = write_q ? '0 : rsp_i.rdata;
                        state_d = RESP;
                    end else if (write_q) begin
                        rdata_d = '0;
                        state_d = RESP;
                    end else if (!poll_q || poll_match) begin
                        rdata_d = rsp_i.rdata;
                        state_d = RESP;
                    end else begin
                        iter_d = iter_inc;
                        if (iter_inc == IterW'(PollMaxIter)) begin
                            rdata_d   = rsp_i.rdata;
                            timeout_d = 1'b1;
                            state_d   = RESP;
                        end else begin
                            gap_d   = GapW'(PollGap - 1);
                            state_d = GAP;
                        end
                    end
                end
            end
            GAP: begin
                if (gap_q == '0) begin
                    state_d = ISSUE;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
            RESP: begin
                if (res_ready_i) begin
                    error_d   = 1'b0;
                    timeout_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            write_q   <= 1'b0;
            wdata_q   <= '0;
            poll_q    <= 1'b0;
            mask_q    <= '0;
            iter_q    <= '0;
            gap_q     <= '0;
            rdata_q   <= '0;
            error_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            write_q   <= write_d;
            wdata_q   <= wdata_d;
            poll_q    <= poll_d;
            mask_q    <= mask_d;
            iter_q    <= iter_d;
            gap_q     <= gap_d;
            rdata_q   <= rdata_d;
            error_q   <= error_d;
            timeout_q <= timeout_d;
        end
    end

    // Request fields are driven only while issuing; all zero otherwise
    always_comb begin
        req_o = '0;
        if (state_q == ISSUE) begin
            req_o.valid = 1'b1;
            req_o.addr  = addr_q;
            req_o.write = write_q;
            req_o.wdata = write_q ? wdata_q : '0;
            req_o.wstrb = write_q ? '1 : '0;
        end
    end

    assign cmd_ready_o   = (state_q == IDLE);
    assign res_valid_o   = (state_q == RESP);
    assign res_rdata_o   = rdata_q;
    assign res_error_o   = error_q;
    assign res_timeout_o = timeout_q;

endmodule

// File: tb/tb_conv1d_reg_initiator.sv
// Directed bench for conv1d_reg_initiator (PollMaxIter=3, PollGap=4).
module tb_conv1d_reg_initiator;

    localparam int MaxIter = 3;
    localparam int Gap     = 4;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_addr;
    logic        cmd_write;
    logic [31:0] cmd_wdata;
    logic        cmd_poll;
    logic [31:0] cmd_mask;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_rdata;
    logic        res_error;
    logic        res_timeout;
    conv1d_reg_pkg::reg_req_t req;
    conv1d_reg_pkg::reg_rsp_t rsp;

    int tests_run    = 0;
    int tests_failed = 0;

    conv1d_reg_initiator #(
        .AddrWidth  (32),
        .DataWidth  (32),
        .PollMaxIter(MaxIter),
        .PollGap    (Gap)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .cmd_valid_i  (cmd_valid),
        .cmd_ready_o  (cmd_ready),
        .cmd_addr_i   (cmd_addr),
        .cmd_write_i  (cmd_write),
        .cmd_wdata_i  (cmd_wdata),
        .cmd_poll_i   (cmd_poll),
        .cmd_mask_i   (cmd_mask),
        .res_valid_o  (res_valid),
        .res_ready_i  (res_ready),
        .res_rdata_o  (res_rdata),
        .res_error_o  (res_error),
        .res_timeout_o(res_timeout),
        .req_o        (req),
        .rsp_i        (rsp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one command for one cycle; caller is at posedge+1 with DUT idle.
    task automatic send_cmd(input logic [31:0] a, input logic w, input logic [31:0] d,
                            input logic p, input logic [31:0] m);
        cmd_valid = 1'b1;
        cmd_addr  = a;
        cmd_write = w;
        cmd_wdata = d;
        cmd_poll  = p;
        cmd_mask  = m;
        step();
        cmd_valid = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        cmd_mask  = '0;
    endtask

    // Bus responder/monitor. Cycle 0 is the first cycle after command accept.
    // Each attempt is answered after wait_cyc stall cycles with d0/d1/d2;
    // attempt err_att (1-based) answers with error. Outside a request,
    // rsp.ready is driven high to exercise that it is ignored.
    task automatic serve(input int wait_cyc, input logic [31:0] d0, input logic [31:0] d1,
                         input logic [31:0] d2, input int err_att,
                         output int n_valid, output int n_att, output int res_cyc,
                         output bit stable, output bit gap_ok,
                         output conv1d_reg_pkg::reg_req_t first);
        bit prev_valid = 0;
        int att_start  = 0;
        int idle_cnt   = 0;
        n_valid = 0;
        n_att   = 0;
        res_cyc = -1;
        stable  = 1;
        gap_ok  = 1;
        first   = '0;
        for (int cyc = 0; cyc < 80; cyc++) begin
            if (res_valid) begin
                res_cyc = cyc;
                break;
            end
            if (req.valid) begin
                if (!prev_valid) begin
                    n_att++;
                    att_start = cyc;
                    if (n_att == 1) first = req;
                    else if (idle_cnt != Gap) gap_ok = 0;
                end
                if (req !== first) stable = 0;
                n_valid++;
                idle_cnt = 0;
                if (cyc - att_start >= wait_cyc) begin
                    rsp.ready = 1'b1;
                    rsp.rdata = (n_att == 1) ? d0 : (n_att == 2) ? d1 : d2;
                    rsp.error = (n_att == err_att);
                end else begin
                    rsp.ready = 1'b0;
                    rsp.rdata = 32'hDEAD_BEEF;
                    rsp.error = 1'b1;
                end
            end else begin
                if (n_att > 0) idle_cnt++;
                rsp.ready = 1'b1;
                rsp.rdata = 32'hFFFF_FFFF;
                rsp.error = 1'b1;
            end
            prev_valid = req.valid;
            step();
        end
        rsp = '0;
    endtask

    task automatic ack_result();
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        tests_run++;
        if (req !== '0 || res_valid !== 1'b0 || res_rdata !== '0 || res_error !== 1'b0 ||
            res_timeout !== 1'b0 || cmd_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_values: req=%h res_valid=%b rdata=%h err=%b to=%b cmd_ready=%b, want all 0 and cmd_ready=1",
                     req, res_valid, res_rdata, res_error, res_timeout, cmd_ready);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_write();
        int nv, na, rc;
        bit st, go;
        conv1d_reg_pkg::reg_req_t f;
        send_cmd(32'h04, 1'b1, 32'hA5A5_0001, 1'b0, 32'h0);
        serve(2, 32'h5555_5555, 32'h0, 32'h0, 0, nv, na, rc, st, go, f);
        tests_run++;
        if (nv !== 3 || !st) begin
            tests_failed++;
            $display("FAIL write_valid_cycles: got %0d stable=%0d, want 3 stable=1", nv, st);
        end
        tests_run++;
        if (f.addr !== 32'h04 || f.write !== 1'b1 || f.wdata !== 32'hA5A5_0001 || f.wstrb !== 4'hF) begin
            tests_failed++;
            $display("FAIL write_req_fields: addr=%h wr=%b wdata=%h wstrb=%h, want 04 1 a5a50001 f",
                     f.addr, f.write, f.wdata, f.wstrb);
        end
        tests_run++;
        if (rc !== 3 || res_rdata !== 32'h0 || res_error !== 1'b0 || res_timeout !== 1'b0) begin
            tests_failed++;
            $display("FAIL write_result: cyc=%0d rdata=%h err=%b to=%b, want 3 0 0 0",
                     rc, res_rdata, res_error, res_timeout);
        end
        ack_result();
        tests_run++;
        if (res_valid !== 1'b0 || cmd_ready !== 1'b1 || res_error !== 1'b0) begin
            tests_failed++;
            $display("FAIL write_ack: res_valid=%b cmd_ready=%b, want 0 1", res_valid, cmd_ready);
        end
    endtask

    task automatic test_read();
        int nv, na, rc;
        bit st, go;
        conv1d_reg_pkg::reg_req_t f;
        send_cmd(32'h08, 1'b0, 32'hFFFF_0000, 1'b0, 32'hFFFF_FFFF);
        serve(0, 32'h1234_5678, 32'h0, 32'h0, 0, nv, na, rc, st, go, f);
        tests_run++;
        if (nv !== 1 || f.addr !== 32'h08 || f.write !== 1'b0 || f.wdata !== 32'h0 || f.wstrb !== 4'h0) begin
            tests_failed++;
            $display("FAIL read_req: valid_cycles=%0d addr=%h wr=%b wdata=%h wstrb=%h, want 1 08 0 0 0",
                     nv, f.addr, f.write, f.wdata, f.wstrb);
        end
        // res_valid two cycles after accept = serve cycle 1
        tests_run++;
        if (rc !== 1 || res_rdata !== 32'h1234_5678 || res_error !== 1'b0) begin
            tests_failed++;
            $display("FAIL read_result: cyc=%0d rdata=%h err=%b, want 1 12345678 0", rc, res_rdata, res_error);
        end
        ack_result();
    endtask

    task automatic test_poll_match();
        int nv, na, rc;
        bit st, go;
        conv1d_reg_pkg::reg_req_t f;
        send_cmd(32'h10, 1'b0, 32'h1, 1'b1, 32'h1);
        serve(0, 32'h0, 32'h0, 32'h1, 0, nv, na, rc, st, go, f);
        tests_run++;
        if (na !== 3 || nv !== 3 || !go || !st) begin
            tests_failed++;
            $display("FAIL poll_match_attempts: att=%0d vcyc=%0d gap_ok=%0d stable=%0d, want 3 3 1 1",
                     na, nv, go, st);
        end
        tests_run++;
        if (rc !== 11 || res_rdata !== 32'h1 || res_timeout !== 1'b0 || res_error !== 1'b0) begin
            tests_failed++;
            $display("FAIL poll_match_result: cyc=%0d rdata=%h to=%b err=%b, want 11 1 0 0",
                     rc, res_rdata, res_timeout, res_error);
        end
        ack_result();
    endtask

    task automatic test_poll_timeout();
        int nv, na, rc;
        bit st, go;
        conv1d_reg_pkg::reg_req_t f;
        send_cmd(32'h14, 1'b0, 32'h1, 1'b1, 32'h1);
        serve(0, 32'h0, 32'h0, 32'h0, 0, nv, na, rc, st, go, f);
        tests_run++;
        if (na !== MaxIter || !go) begin
            tests_failed++;
            $display("FAIL poll_timeout_attempts: att=%0d gap_ok=%0d, want 3 1", na, go);
        end
        tests_run++;
        if (rc !== 11 || res_timeout !== 1'b1 || res_rdata !== 32'h0 || res_error !== 1'b0) begin
            tests_failed++;
            $display("FAIL poll_timeout_result: cyc=%0d to=%b rdata=%h err=%b, want 11 1 0 0",
                     rc, res_timeout, res_rdata, res_error);
        end
        ack_result();
        tests_run++;
        if (res_timeout !== 1'b0 || cmd_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL poll_timeout_clear: to=%b cmd_ready=%b, want 0 1", res_timeout, cmd_ready);
        end
    endtask

    task automatic test_poll_error();
        int nv, na, rc;
        bit st, go;
        conv1d_reg_pkg::reg_req_t f;
        // Mask 0x2 with match 0x2: attempt 3 would match if it were ever issued.
        send_cmd(32'h18, 1'b0, 32'h2, 1'b1, 32'h2);
        serve(0, 32'h0, 32'h0, 32'h2, 2, nv, na, rc, st, go, f);
        tests_run++;
        if (na !== 2 || rc !== 6) begin
            tests_failed++;
            $display("FAIL poll_error_attempts: att=%0d cyc=%0d, want 2 6", na, rc);
        end
        tests_run++;
        if (res_error !== 1'b1 || res_timeout !== 1'b0) begin
            tests_failed++;
            $display("FAIL poll_error_result: err=%b to=%b, want 1 0", res_error, res_timeout);
        end
        ack_result();
    endtask

    task automatic test_backpressure();
        int nv, na, rc;
        bit st, go;
        bit held = 1;
        conv1d_reg_pkg::reg_req_t f;
        send_cmd(32'h20, 1'b0, 32'h0, 1'b0, 32'h0);
        serve(0, 32'hCAFE_0042, 32'h0, 32'h0, 0, nv, na, rc, st, go, f);
        // A second command offered while busy must not be taken.
        cmd_valid = 1'b1;
        cmd_addr  = 32'h24;
        cmd_write = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (res_valid !== 1'b1 || res_rdata !== 32'hCAFE_0042 || cmd_ready !== 1'b0 ||
                req.valid !== 1'b0) held = 0;
            step();
        end
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        tests_run++;
        if (!held || res_valid !== 1'b1 || res_rdata !== 32'hCAFE_0042) begin
            tests_failed++;
            $display("FAIL backpressure_hold: held=%0d res_valid=%b rdata=%h, want 1 1 cafe0042",
                     held, res_valid, res_rdata);
        end
        ack_result();
        step();
        tests_run++;
        if (req.valid !== 1'b0 || cmd_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL backpressure_no_queue: req.valid=%b cmd_ready=%b, want 0 1", req.valid, cmd_ready);
        end
    endtask

    task automatic test_reset_in_gap();
        int nv, na, rc;
        bit st, go;
        bit quiet = 1;
        conv1d_reg_pkg::reg_req_t f;
        send_cmd(32'h30, 1'b0, 32'h1, 1'b1, 32'h1);
        rsp.ready = 1'b1;
        rsp.rdata = 32'h0;
        rsp.error = 1'b0;
        step();
        rsp = '0;
        step();
        tests_run++;
        if (req.valid !== 1'b0 || cmd_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL gap_entered: req.valid=%b cmd_ready=%b, want 0 0", req.valid, cmd_ready);
        end
        #1 rst_n = 1'b0;
        #1;
        tests_run++;
        if (req !== '0 || res_valid !== 1'b0 || res_error !== 1'b0 || res_timeout !== 1'b0 ||
            res_rdata !== '0 || cmd_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_in_gap: req=%h res_valid=%b cmd_ready=%b, want 0 0 1", req, res_valid, cmd_ready);
        end
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (res_valid !== 1'b0 || req.valid !== 1'b0) quiet = 0;
            step();
        end
        tests_run++;
        if (!quiet) begin
            tests_failed++;
            $display("FAIL reset_discard: spurious activity after reset, want none");
        end
        tests_run++;
        if (cmd_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_cmd_ready: got %b, want 1", cmd_ready);
        end
        send_cmd(32'h34, 1'b0, 32'h0, 1'b0, 32'h0);
        serve(0, 32'h0BAD_F00D, 32'h0, 32'h0, 0, nv, na, rc, st, go, f);
        tests_run++;
        if (rc !== 1 || f.addr !== 32'h34 || res_rdata !== 32'h0BAD_F00D) begin
            tests_failed++;
            $display("FAIL reset_new_cmd: cyc=%0d addr=%h rdata=%h, want 1 34 0badf00d", rc, f.addr, res_rdata);
        end
        ack_result();
    endtask

    initial begin
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_addr  = '0;
        cmd_write = 1'b0;
        cmd_wdata = '0;
        cmd_poll  = 1'b0;
        cmd_mask  = '0;
        res_ready = 1'b0;
        rsp       = '0;
        #1;
        test_reset();
        test_write();
        test_read();
        test_poll_match();
        test_poll_timeout();
        test_poll_error();
        test_backpressure();
        test_reset_in_gap();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
